// File: rtl/jk_counter_pkg.sv
// jk_counter_pkg: shared definitions for the J-K modulo counter.
//
// Holds the {j,k} command encoding driven into each J-K stage and the
// modulo next-count helper used by the counter's next-state logic.
//
// Optional build macro used by the counter: JK_COUNTER_SATURATE_EN.

package jk_counter_pkg;

  // {j,k} command applied to one J-K stage.
  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t HOLD   = 2'b00;
  localparam jk_cmd_t RESET  = 2'b01;
  localparam jk_cmd_t SET    = 2'b10;
  localparam jk_cmd_t TOGGLE = 2'b11;

  // Next value of a modulo-'modulus' up/down counter. Out-of-range inputs
  // return 0 so a corrupted count always re-enters the legal sequence.
  function automatic int unsigned next_count(input int unsigned cur,
                                             input logic        up,
                                             input int unsigned modulus);
    if (cur >= modulus) begin
      return 32'd0;
    end
    if (up) begin
      return (cur == modulus - 32'd1) ? 32'd0 : cur + 32'd1;
    end
    return (cur == 32'd0) ? modulus - 32'd1 : cur - 32'd1;
  endfunction

endpackage

// File: rtl/jk_stage.sv
// jk_stage: one J-K flip-flop with asynchronous active-low clear.
//
// Ports:
//   clk   - rising-edge clock
//   clr_n - asynchronous active-low clear, forces q to 0
//   j, k  - J-K inputs: 00 hold, 01 reset, 10 set, 11 toggle
//   q     - stage output
//   q_n   - complemented stage output

module jk_stage
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_n
);

  logic q_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q <= 1'b0;
    end else begin
      unique case ({j, k})
        HOLD:    q_q <= q_q;
        RESET:   q_q <= 1'b0;
        SET:     q_q <= 1'b1;
        TOGGLE:  q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q   = q_q;
  assign q_n = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous modulo-MODULUS up/down counter built from WIDTH
// J-K flip-flop stages. Each cycle the next-state logic issues one {j,k}
// command per stage: TOGGLE/HOLD while counting, SET/RESET while loading or
// recovering from an illegal count.
//
// Parameters:
//   WIDTH   - counter width in bits
//   MODULUS - count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clk      - rising-edge clock
//   clr_n    - asynchronous active-low clear (count, wrap and tc go to 0)
//   en       - count enable
//   up_dn    - 1 counts up, 0 counts down
//   load     - synchronous parallel load, has priority over en
//   load_val - value to load, clamped to MODULUS-1
//   count    - current count (q vector of the stages)
//   tc       - terminal count, combinational
//   wrap     - registered one-cycle pulse after a wrapping count step
//
// Build option: define JK_COUNTER_SATURATE_EN to make counting saturate at
// the terminal value instead of wrapping; wrap then stays 0.

module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("jk_mod_counter: WIDTH must be in 1..31");
  end

  if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] stage_q_n;
  jk_cmd_t [WIDTH-1:0] jk_cmd;

  logic             at_max;
  logic             at_zero;
  logic             illegal;
  logic             tc_raw;
  logic [WIDTH-1:0] load_tgt;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] next_val;
  logic             wrap_d;
  logic             wrap_q;

  assign at_max  = (stage_q == MaxVal);
  // All complemented outputs high means every stage holds 0.
  assign at_zero = &stage_q_n;
  assign illegal = (32'(stage_q) >= MODULUS);

  assign load_tgt = (32'(load_val) >= MODULUS) ? MaxVal : load_val;
  assign step_val = WIDTH'(next_count(32'(stage_q), up_dn, MODULUS));

  assign tc_raw = en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

  always_comb begin
    next_val = stage_q;
    wrap_d   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      jk_cmd[i] = HOLD;
    end

    if (load) begin
      next_val = load_tgt;
      for (int i = 0; i < WIDTH; i++) begin
        jk_cmd[i] = next_val[i] ? SET : RESET;
      end
    end else if (en) begin
      if (illegal) begin
        // Explicit SET/RESET so recovery does not depend on the corrupted q.
        next_val = '0;
        for (int i = 0; i < WIDTH; i++) begin
          jk_cmd[i] = next_val[i] ? SET : RESET;
        end
      end else begin
`ifdef JK_COUNTER_SATURATE_EN
        next_val = tc_raw ? stage_q : step_val;
`else
        next_val = step_val;
        wrap_d   = tc_raw;
`endif
        for (int i = 0; i < WIDTH; i++) begin
          jk_cmd[i] = (stage_q[i] ^ next_val[i]) ? TOGGLE : HOLD;
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_stage u_stage (
      .clk   (clk),
      .clr_n (clr_n),
      .j     (jk_cmd[i][1]),
      .k     (jk_cmd[i][0]),
      .q     (stage_q[i]),
      .q_n   (stage_q_n[i])
    );
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign count = stage_q;
  // Clear holds tc low even though en/up_dn may describe a terminal state.
  assign tc    = tc_raw & clr_n;
  assign wrap  = wrap_q;

endmodule
